// File: rtl/sum_acc_pkg.sv
// -----------------------------------------------------------------------------
// sum_acc_pkg
//   Shared types and default sizing for the sum accumulator and the adder
//   stage that feeds it.
//     DEF_WIDTH   : width of one adder result
//     DEF_COUNT   : beats folded into one accumulated total
//     acc_state_t : accumulator FSM states
// -----------------------------------------------------------------------------
package sum_acc_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_COUNT = 4;

  typedef enum logic {
    ACCUM, // gathering beats
    HOLD   // presenting a completed total
  } acc_state_t;

endpackage

// File: rtl/sum_accumulator.sv
// -----------------------------------------------------------------------------
// sum_accumulator
//   Consumes a stream of unsigned adder results through a valid/ready
//   handshake and folds COUNT accepted beats into one widened total.
//   The total is then offered through an output valid/ready handshake.
//   While a total is held, the input side is stalled.
//
// Ports
//   clk        in   1      clock, all state on rising edge
//   rst        in   1      synchronous reset, active-high
//   clear      in   1      drops the partial block (ignored while holding)
//   in_valid   in   1      in_sum is valid this cycle
//   in_ready   out  1      a beat can be accepted this cycle
//   in_sum     in   WIDTH  adder result, unsigned
//   out_valid  out  1      out_acc holds a completed total
//   out_ready  in   1      sink takes out_acc this cycle
//   out_acc    out  ACC_W  total of COUNT beats
// -----------------------------------------------------------------------------
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int COUNT = DEF_COUNT,             // must be >= 2
  localparam int ACC_W = WIDTH + $clog2(COUNT)  // COUNT*(2^WIDTH-1) always fits
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc
);

  localparam int              CNT_W    = $clog2(COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  acc_state_t       state;
  acc_state_t       state_next;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_beat;

  // Gated by rst and clear so a beat offered in those cycles is never taken.
  assign in_ready  = (state == ACCUM) && !clear && !rst;
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt == CNT_LAST);
  assign acc_sum   = acc + ACC_W'(in_sum);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_next = state;
    case (state)
      ACCUM:   if (accept && last_beat) state_next = HOLD;
      HOLD:    if (out_ready)           state_next = ACCUM;
      default:                          state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_acc   <= '0;
    end else begin
      state <= state_next;
      if (state == ACCUM) begin
        // clear and accept are mutually exclusive: in_ready is low under clear.
        if (clear) begin
          acc <= '0;
          cnt <= '0;
        end else if (accept) begin
          if (last_beat) begin
            out_acc   <= acc_sum;
            out_valid <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
          end else begin
            acc <= acc_sum;
            cnt <= cnt + CNT_W'(1);
          end
        end
      end else if (out_ready) begin
        // out_acc deliberately keeps its last total after the handshake.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// -----------------------------------------------------------------------------
// tb_sum_accumulator
//   Directed bench for sum_accumulator (WIDTH=4, COUNT=4, ACC_W=6).
//   Inputs change 1 ns after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_sum_accumulator;

  localparam int WIDTH = 4;
  localparam int COUNT = 4;
  localparam int ACC_W = 6;

  logic             clk;
  logic             rst;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;

  int compared   = 0;
  int mismatched = 0;

  sum_accumulator #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat for exactly one edge; the DUT must be ready for it.
  task automatic send(input logic [WIDTH-1:0] s);
    in_valid = 1'b1;
    in_sum   = s;
    #1;
    check("in_ready_on_beat", in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_sum   = '0;
  endtask

  // Complete the output handshake and confirm the return to ACCUM.
  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("drain_out_valid", out_valid, 0);
    check("drain_in_ready",  in_ready,  1);
  endtask

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    out_ready = 1'b0;

    // 1. Reset held for three edges
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_in_ready", in_ready, 0);
    end
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_acc",   out_acc,   0);
    check("rst_in_ready_after", in_ready, 1);

    // 2. Back-to-back beats 3,5,7,1 -> 16
    send(4'd3);
    send(4'd5);
    send(4'd7);
    check("b2b_no_early_valid", out_valid, 0);
    send(4'd1);
    check("b2b_out_valid", out_valid, 1);
    check("b2b_out_acc",   out_acc,   16);
    check("b2b_in_ready",  in_ready,  0);

    // 4. Backpressure: hold total for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_out_acc",   out_acc,   16);
      check("bp_in_ready",  in_ready,  0);
    end
    drain();
    check("bp_acc_kept", out_acc, 16);

    // 3. Max values: 4 x 15 -> 60, no wrap
    for (int i = 0; i < 4; i++) send(4'd15);
    check("max_out_valid", out_valid, 1);
    check("max_out_acc",   out_acc,   60);
    drain();

    // 5. Clear drops the partial block and the coincident beat
    send(4'd2);
    send(4'd2);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_sum   = 4'd9;
    #1;
    check("clr_in_ready", in_ready, 0);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) send(4'd1);
    check("clr_no_early_valid", out_valid, 0);
    send(4'd1);
    check("clr_out_valid", out_valid, 1);
    check("clr_out_acc",   out_acc,   4);

    // clear while holding has no effect
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_hold_out_valid", out_valid, 1);
    check("clr_hold_out_acc",   out_acc,   4);
    drain();

    // 6. Gaps, then a mid-block reset
    send(4'd4);
    tick();
    check("gap_acc_hold", out_valid, 0);
    send(4'd4);
    tick();
    send(4'd4);
    check("gap_no_valid", out_valid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_acc",   out_acc,   0);
    check("mid_rst_in_ready",  in_ready,  1);
    send(4'd1);
    send(4'd2);
    send(4'd3);
    check("post_rst_no_early_valid", out_valid, 0);
    send(4'd4);
    check("post_rst_out_valid", out_valid, 1);
    check("post_rst_out_acc",   out_acc,   10);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
